// File: rtl/rle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rle_pkg
//  Description : Shared widths, saturation constant, token layout and run
//                state encoding for the run-length token packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rle_pkg;

   localparam int c_data_w     = 8;
   localparam int c_len_w      = 8;
   localparam int c_token_w    = c_data_w + c_len_w;
   localparam int c_fifo_depth = 4;
   localparam int c_max_len    = (1 << c_len_w) - 1;

   // One closed run: the repeated value and how many samples it spanned
   typedef struct packed {
      logic [c_data_w-1:0] val;
      logic [c_len_w-1:0]  len;
   } token_t;

   // IDLE: no run being accumulated; RUN: cur_val/cur_len describe an open run
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } run_state_t;

endpackage
`default_nettype wire

// File: rtl/rle_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rle_sync_fifo
//  Description : Small single-clock first-word-fall-through FIFO with
//                register storage. Head entry is always presented on
//                pop_data; a push into a full FIFO is only taken when a pop
//                frees a slot in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module rle_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;

   logic w_do_pop;
   logic w_do_push;

   assign full      = (r_count == c_cnt_w'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_do_pop  = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign w_do_push = push & (~full | w_do_pop);
   assign pop_data  = r_mem[r_rd_ptr];

   // Storage, pointers (wrap naturally at power-of-two depth) and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/rle_token_packer.sv
`default_nettype none
// ============================================================================
//  Module      : rle_token_packer
//  Description : Run-length encoder. Accumulates runs of identical sample
//                values, closes each run into a {value, length} token
//                (on value change, length saturation or flush) and buffers
//                tokens in a FIFO drained over valid/ready. A sticky flag
//                reports any token lost to a full buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module rle_token_packer
   import rle_pkg::*;
#(
   parameter int DATA_W     = c_data_w,
   parameter int LEN_W      = c_len_w,
   parameter int FIFO_DEPTH = c_fifo_depth
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] val,
   input  logic              in_valid,
   input  logic              flush,
   output logic [DATA_W-1:0] tok_val,
   output logic [LEN_W-1:0]  tok_len,
   output logic              tok_valid,
   input  logic              tok_ready,
   output logic              overflow,
   output logic              run_open
);

   localparam int               c_tok_w   = DATA_W + LEN_W;
   localparam logic [LEN_W-1:0] c_len_sat = '1;

   run_state_t          r_state;
   logic [DATA_W-1:0]   r_cur_val;
   logic [LEN_W-1:0]    r_cur_len;
   logic                r_overflow;

   logic                w_push;
   logic [c_tok_w-1:0]  w_push_tok;
   logic [c_tok_w-1:0]  w_head;
   logic                w_full;
   logic                w_empty;
   logic                w_pop;

   // Decide whether this cycle closes the open run into a token
   always_comb begin
      w_push     = 1'b0;
      w_push_tok = {r_cur_val, r_cur_len};
      if (r_state == RUN) begin
         if (in_valid) begin
            w_push = (val != r_cur_val) || (r_cur_len == c_len_sat);
         end else if (flush) begin
            w_push = 1'b1;
         end
      end
   end

   // Run accumulation state machine
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cur_val <= '0;
         r_cur_len <= '0;
      end else if (in_valid) begin
         if (r_state == IDLE || val != r_cur_val) begin
            r_state   <= RUN;
            r_cur_val <= val;
            r_cur_len <= LEN_W'(1);
         end else if (r_cur_len == c_len_sat) begin
            // Saturated run was emitted; same value starts a fresh run
            r_cur_len <= LEN_W'(1);
         end else begin
            r_cur_len <= r_cur_len + LEN_W'(1);
         end
      end else if (flush && r_state == RUN) begin
         r_state   <= IDLE;
         r_cur_len <= '0;
      end
   end

   // Sticky record of a token dropped because the buffer had no room
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_push && w_full && !w_pop) begin
         r_overflow <= 1'b1;
      end
   end

   assign w_pop = ~w_empty & tok_ready;

   rle_sync_fifo #(
      .WIDTH (c_tok_w),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data (w_push_tok),
      .pop       (w_pop),
      .pop_data  (w_head),
      .full      (w_full),
      .empty     (w_empty)
   );

   assign tok_val   = w_head[c_tok_w-1:LEN_W];
   assign tok_len   = w_head[LEN_W-1:0];
   assign tok_valid = ~w_empty;
   assign overflow  = r_overflow;
   assign run_open  = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_rle_token_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rle_token_packer
//  Description : Self-checking bench for rle_token_packer. Stimulus pushes
//                hand-computed tokens into a scoreboard queue; a monitor
//                compares every accepted output token against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rle_token_packer;
   import rle_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] val;
   logic       in_valid;
   logic       flush;
   logic       tok_ready;
   logic [7:0] tok_val;
   logic [7:0] tok_len;
   logic       tok_valid;
   logic       overflow;
   logic       run_open;

   int n_checks = 0;
   int n_fail   = 0;
   token_t exp_q[$];

   rle_token_packer #(
      .DATA_W     (8),
      .LEN_W      (8),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .val       (val),
      .in_valid  (in_valid),
      .flush     (flush),
      .tok_val   (tok_val),
      .tok_len   (tok_len),
      .tok_valid (tok_valid),
      .tok_ready (tok_ready),
      .overflow  (overflow),
      .run_open  (run_open)
   );

   always #5 clk = ~clk;

   // Monitor: each handshake seen mid-cycle is consumed at the next posedge
   always @(negedge clk) begin
      if (!rst && tok_valid && tok_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL token_unexpected: got {%0h,%0d}, required none", tok_val, tok_len);
         end else begin
            token_t e;
            e = exp_q.pop_front();
            if (tok_val !== e.val || tok_len !== e.len) begin
               n_fail++;
               $display("FAIL token: got {%0h,%0d}, required {%0h,%0d}",
                        tok_val, tok_len, e.val, e.len);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] v, input logic [7:0] l);
      token_t t;
      t.val = v;
      t.len = l;
      exp_q.push_back(t);
   endtask

   task automatic sample(input logic [7:0] v);
      val      = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic drain(input string name, input int max_cycles);
      int k = 0;
      while ((exp_q.size() != 0 || tok_valid) && k < max_cycles) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk(name, {31'd0, (exp_q.size() == 0 && !tok_valid)}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      val       = '0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      tok_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tok_valid", tok_valid, 0);
      chk("rst_tok_val", tok_val, 0);
      chk("rst_tok_len", tok_len, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_run_open", run_open, 0);
      rst = 1'b0;

      // Basic run closed by a value change, then the 9-run flushed
      tok_ready = 1'b1;
      sample(8'd5);
      sample(8'd5);
      sample(8'd5);
      push_exp(8'd5, 8'd3);
      sample(8'd9);
      chk("t1_tok_valid", tok_valid, 1);
      chk("t1_tok_val", tok_val, 5);
      chk("t1_tok_len", tok_len, 3);
      chk("t1_run_open", run_open, 1);
      push_exp(8'd9, 8'd1);
      do_flush();
      chk("t1_flush_run_open", run_open, 0);
      drain("t1_drain", 20);

      // Idle gaps must not split a run
      sample(8'd7);
      idle(2);
      chk("t2_gap_run_open", run_open, 1);
      chk("t2_gap_no_token", tok_valid, 0);
      sample(8'd7);
      push_exp(8'd7, 8'd2);
      sample(8'd3);
      chk("t2_tok_len", tok_len, 2);
      push_exp(8'd3, 8'd1);
      do_flush();
      drain("t2_drain", 20);

      // Saturation at 255 then the remainder flushed
      for (int i = 0; i < 257; i++) begin
         if (i == 255) push_exp(8'hAA, 8'd255);
         sample(8'hAA);
         if (i == 254) chk("t3_no_token_at_255", tok_valid, 0);
         if (i == 255) chk("t3_sat_len", tok_len, 255);
      end
      push_exp(8'hAA, 8'd2);
      do_flush();
      chk("t3_run_open", run_open, 0);
      drain("t3_drain", 20);

      // Back-pressure: fill FIFO, drop tokens, overflow stays sticky
      tok_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (i >= 1 && i <= 4) push_exp((i % 2 == 1) ? 8'd1 : 8'd2, 8'd1);
         sample((i % 2 == 1) ? 8'd2 : 8'd1);
         if (i == 4) chk("t4_full_no_ovf", overflow, 0);
         if (i == 5) chk("t4_ovf_set", overflow, 1);
      end
      chk("t4_tok_valid", tok_valid, 1);
      chk("t4_head_val", tok_val, 1);
      tok_ready = 1'b1;
      drain("t4_drain", 20);
      chk("t4_ovf_sticky", overflow, 1);
      chk("t4_run_open", run_open, 1);

      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t4_rst_ovf", overflow, 0);
      chk("t4_rst_run_open", run_open, 0);

      // Full FIFO with simultaneous push and pop
      tok_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i >= 1) push_exp((i % 2 == 1) ? 8'd1 : 8'd2, 8'd1);
         sample((i % 2 == 1) ? 8'd2 : 8'd1);
      end
      chk("t5_full_valid", tok_valid, 1);
      tok_ready = 1'b1;
      push_exp(8'd1, 8'd1);
      sample(8'd2);
      chk("t5_no_ovf", overflow, 0);
      idle(3);
      chk("t5_still_one", tok_valid, 1);
      idle(1);
      chk("t5_empty_after_4", tok_valid, 0);
      chk("t5_queue_empty", exp_q.size(), 0);

      // Reset mid-run with tokens queued
      tok_ready = 1'b0;
      sample(8'd4);
      sample(8'd5);
      chk("t6_queued", tok_valid, 1);
      chk("t6_run_open", run_open, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t6_rst_tok_valid", tok_valid, 0);
      chk("t6_rst_run_open", run_open, 0);
      chk("t6_rst_ovf", overflow, 0);
      chk("t6_rst_tok_len", tok_len, 0);
      tok_ready = 1'b1;
      do_flush();
      chk("t6_flush_no_token", tok_valid, 0);
      idle(2);
      chk("t6_flush_no_token_later", tok_valid, 0);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
